// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared constants and types for the router datapath
//             (input FSM, synchronizer, output FIFOs).
//  Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  // Number of output ports / FIFOs
  localparam int NUM_PORTS = 3;

  // Address value meaning "no destination latched"
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Default unread-data timeout in clock cycles
  localparam int TIMEOUT_DEFAULT = 30;

  // Destination port index carried in header bits [1:0]
  typedef enum logic [1:0] {
    PORT_0    = 2'b00,
    PORT_1    = 2'b01,
    PORT_2    = 2'b10,
    PORT_NONE = 2'b11
  } port_idx_e;

  // One-hot write-enable pattern for a port index; all zero for PORT_NONE
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_e idx);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (idx)
      PORT_0:  oh = 3'b001;
      PORT_1:  oh = 3'b010;
      PORT_2:  oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_sync_timer.sv
`default_nettype none
// ============================================================================
//  Module   : router_sync_timer
//  Purpose  : Per-port unread-data watchdog. Counts consecutive cycles in
//             which the port holds valid data that nobody reads, and emits a
//             one-cycle soft reset when the count reaches TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld,
  input  logic rd_enb,
  output logic sft_rst
);

  // Last count value before the soft reset fires
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stall;

  // A stall cycle: data waiting and no read this cycle
  assign stall = vld & ~rd_enb;

  // Stall counter and soft-reset pulse; the counter wraps to zero on the
  // firing edge so the pulse can never last two consecutive cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      sft_rst <= 1'b0;
    end else if (!stall) begin
      cnt_q   <= '0;
      sft_rst <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      sft_rst <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      sft_rst <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_sync.sv
`default_nettype none
// ============================================================================
//  Module   : router_sync
//  Purpose  : Glue between the router input FSM and the three output FIFOs.
//             Latches the header destination, steers the FSM write strobe to
//             the addressed FIFO, returns that FIFO's full flag, drives the
//             per-port valid outputs and the per-port timeout soft resets.
//  Revision : 1.0 - initial release
// ============================================================================
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       rd_enb_0,
  input  logic       rd_enb_1,
  input  logic       rd_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       sft_rst_0,
  output logic       sft_rst_1,
  output logic       sft_rst_2
);

  logic [1:0]           addr_q;
  logic [NUM_PORTS-1:0] vld_vec;
  logic [NUM_PORTS-1:0] rd_vec;
  logic [NUM_PORTS-1:0] sft_vec;

  // Destination address register; loaded on the header strobe only, so a
  // write in the same cycle as detect_add still uses the previous address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= ADDR_INVALID;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Write steering and full-flag return, both driven by the latched address
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (write_enb_reg) begin
      write_enb = port_onehot(port_idx_e'(addr_q));
    end
    case (port_idx_e'(addr_q))
      PORT_0:  fifo_full = full_0;
      PORT_1:  fifo_full = full_1;
      PORT_2:  fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  // Valid follows FIFO occupancy directly, independent of reset
  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
  assign rd_vec  = {rd_enb_2, rd_enb_1, rd_enb_0};

  // One independent watchdog per output port
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      router_sync_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
      ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .vld     (vld_vec[p]),
        .rd_enb  (rd_vec[p]),
        .sft_rst (sft_vec[p])
      );
    end
  endgenerate

  assign sft_rst_0 = sft_vec[0];
  assign sft_rst_1 = sft_vec[1];
  assign sft_rst_2 = sft_vec[2];

endmodule
`default_nettype wire

// File: tb/tb_router_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_sync
//  Purpose  : Self-checking bench for router_sync: directed scenarios plus a
//             randomized run, compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_sync;

  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] rd;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       sft_rst_0, sft_rst_1, sft_rst_2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_addr;     // 0..2 valid port, 3 = none
  int         m_run [3];  // consecutive stall edges since the stall began
  logic [2:0] m_sft;

  router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .rd_enb_0      (rd[0]),
    .rd_enb_1      (rd[1]),
    .rd_enb_2      (rd[2]),
    .empty_0       (empty[0]),
    .empty_1       (empty[1]),
    .empty_2       (empty[2]),
    .full_0        (full[0]),
    .full_1        (full[1]),
    .full_2        (full[2]),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .sft_rst_0     (sft_rst_0),
    .sft_rst_1     (sft_rst_1),
    .sft_rst_2     (sft_rst_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 3;
    m_sft  = '0;
    for (int p = 0; p < 3; p++) m_run[p] = 0;
  endtask

  // Compare every output against the model, clock one edge, advance the model
  task automatic step();
    logic [2:0] exp_we;
    logic       exp_ff;
    #1;
    exp_we = (write_enb_reg && m_addr != 3) ? 3'(1 << m_addr) : 3'b000;
    exp_ff = (m_addr == 3) ? 1'b0 : full[m_addr];
    chk("write_enb", {5'd0, write_enb}, {5'd0, exp_we});
    chk("fifo_full", {7'd0, fifo_full}, {7'd0, exp_ff});
    chk("vld_out", {5'd0, vld_out_2, vld_out_1, vld_out_0}, {5'd0, ~empty});
    chk("sft_rst", {5'd0, sft_rst_2, sft_rst_1, sft_rst_0}, {5'd0, m_sft});
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (!empty[p] && !rd[p]) begin
          m_run[p]++;
          m_sft[p] = (m_run[p] % TIMEOUT == 0);
        end else begin
          m_run[p] = 0;
          m_sft[p] = 1'b0;
        end
      end
      if (detect_add) m_addr = int'(data_in);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b0;
    rd            = '0;
    empty         = 3'b111;
    full          = '0;
  endtask

  task automatic header(input logic [1:0] a);
    detect_add = 1'b1;
    data_in    = a;
    step();
    detect_add = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    @(negedge clk);

    // ---- Reset state ----
    #1;
    chk("rst_we", {5'd0, write_enb}, 8'h00);
    chk("rst_ff", {7'd0, fifo_full}, 8'h00);
    chk("rst_sft", {5'd0, sft_rst_2, sft_rst_1, sft_rst_0}, 8'h00);
    chk("rst_vld", {5'd0, vld_out_2, vld_out_1, vld_out_0}, 8'h00);
    step();
    rstn = 1'b1;
    write_enb_reg = 1'b1;
    step();
    write_enb_reg = 1'b0;

    // ---- Steering ----
    header(2'b01);
    write_enb_reg = 1'b1;
    repeat (22) step();
    #1 chk("steer_01", {5'd0, write_enb}, 8'h02);
    full = 3'b010;
    step();
    #1 chk("full_sel1", {7'd0, fifo_full}, 8'h01);
    full = 3'b001;
    step();
    #1 chk("full_other", {7'd0, fifo_full}, 8'h00);
    full = '0;
    header(2'b10);
    #1 chk("steer_10", {5'd0, write_enb}, 8'h04);
    step();

    // ---- Invalid address and same-cycle update ----
    header(2'b11);
    full = 3'b111;
    #1 chk("inv_we", {5'd0, write_enb}, 8'h00);
    chk("inv_ff", {7'd0, fifo_full}, 8'h00);
    step();
    full = '0;
    header(2'b01);
    detect_add = 1'b1;
    data_in    = 2'b10;
    #1 chk("same_old", {5'd0, write_enb}, 8'h02);
    step();
    detect_add = 1'b0;
    #1 chk("same_new", {5'd0, write_enb}, 8'h04);
    step();
    write_enb_reg = 1'b0;

    // ---- Timeout fires on port 2 ----
    empty[2] = 1'b0;
    repeat (29) step();
    #1 chk("to2_pre", {5'd0, sft_rst_2, sft_rst_1, sft_rst_0}, 8'h00);
    step();
    #1 chk("to2_fire", {5'd0, sft_rst_2, sft_rst_1, sft_rst_0}, 8'h04);
    empty[2] = 1'b1;
    step();
    #1 chk("to2_once", {5'd0, sft_rst_2, sft_rst_1, sft_rst_0}, 8'h00);
    repeat (3) step();

    // ---- Read during stall cycle 29 restarts port 0 ----
    empty[0] = 1'b0;
    repeat (28) step();
    rd[0] = 1'b1;
    step();
    rd[0] = 1'b0;
    repeat (29) step();
    #1 chk("rd0_nofire", {7'd0, sft_rst_0}, 8'h00);
    step();
    #1 chk("rd0_fire", {7'd0, sft_rst_0}, 8'h01);
    empty[0] = 1'b1;
    step();

    // ---- Reset mid-count on port 1 ----
    header(2'b01);
    write_enb_reg = 1'b1;
    empty[1] = 1'b0;
    repeat (19) step();
    rstn = 1'b0;
    model_reset();
    #1 chk("mid_we", {5'd0, write_enb}, 8'h00);
    chk("mid_sft", {7'd0, sft_rst_1}, 8'h00);
    step();
    rstn = 1'b1;
    repeat (11) step();
    #1 chk("mid_nofire", {7'd0, sft_rst_1}, 8'h00);
    repeat (19) step();
    #1 chk("mid_fire", {7'd0, sft_rst_1}, 8'h01);
    idle_inputs();
    step();

    // ---- Randomized run ----
    for (int n = 0; n < 3000; n++) begin
      detect_add    = ($urandom_range(0, 7) == 0);
      data_in       = 2'($urandom_range(0, 3));
      write_enb_reg = 1'($urandom);
      full          = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 39) == 0) empty[p] = ~empty[p];
        rd[p] = ($urandom_range(0, 34) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        model_reset();
      end else begin
        rstn = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_sync.md
# router_sync

Synchronizer between the router's input FSM and the three output FIFOs (router_fifo).
- Latches the destination address from the header byte.
- Steers the FSM's single write strobe to the one addressed FIFO.
- Returns that FIFO's full flag to the FSM.
- Drives per-port valid outputs.
- Issues a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT consecutive cycles.

## Interface
Parameters:
- TIMEOUT, 30: consecutive valid-but-unread cycles before a port's soft reset fires.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- detect_add  in  1  FSM strobe: the header byte is on the data bus this cycle.
- data_in  in  2  address field of the header, din[1:0].
- write_enb_reg  in  1  FSM write strobe for header, payload and parity bytes.
- rd_enb_0 / rd_enb_1 / rd_enb_2  in  1 each  downstream read enables.
- empty_0 / empty_1 / empty_2  in  1 each  FIFO empty flags.
- full_0 / full_1 / full_2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot wr_enb to FIFO 2..0.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out_0 / vld_out_1 / vld_out_2  out  1 each  data available on the port.
- sft_rst_0 / sft_rst_1 / sft_rst_2  out  1 each  soft reset to the matching FIFO.

## Operation
Address register addr_q (2 bits):
- Reset value 2'b11 (invalid).
- Loads data_in on any edge where detect_add=1; otherwise holds.

write_enb (combinational from addr_q):
- write_enb_reg=1 and addr_q=00/01/10 → 001/010/100.
- addr_q=11 or write_enb_reg=0 → 000.
- If detect_add and write_enb_reg are high in the same cycle, the write goes to the old addr_q. The new address applies from the next cycle.

fifo_full (combinational):
- full_0/1/2 selected by addr_q.
- 0 when addr_q=11.

vld_out_i = ~empty_i (combinational).

Per-port timeout counter cnt_i (CNT_W bits) and registered sft_rst_i. At each rising edge:
- vld_out_i=0 or rd_enb_i=1 → cnt_i<=0, sft_rst_i<=0.
- vld_out_i=1, rd_enb_i=0, cnt_i<TIMEOUT-1 → cnt_i<=cnt_i+1, sft_rst_i<=0.
- vld_out_i=1, rd_enb_i=0, cnt_i==TIMEOUT-1 → cnt_i<=0, sft_rst_i<=1.

Port behaviour:
- The three ports are fully independent; any combination of sft_rst may fire in the same cycle.
- No cross-port interaction except addr_q selection.

## Timing
Reset values:
- rstn low clears addr_q=11, all cnt_i=0, all sft_rst_i=0, immediately (asynchronous).
- write_enb=000 and fifo_full=0 follow combinationally.
- vld_out_i tracks empty_i even during reset.

Latency:
- write_enb and fifo_full: zero-cycle combinational from write_enb_reg, addr_q and full_i.
- Address: takes effect one cycle after the detect_add edge.

Timeout:
- With TIMEOUT=30, a stall that begins in cycle 1 (vld=1, rd=0 sampled at edge 1) drives sft_rst_i high after edge 30, for exactly one cycle.
- During the sft_rst cycle vld may still be 1, so cnt_i counts to 1. It clears once the FIFO reports empty.
- sft_rst_i never stays high for two consecutive cycles.

Mid-operation reset:
- rstn asserted mid-count abandons the count; no sft_rst is emitted.
- addr_q returns to invalid, blocking writes until the next detect_add.

## Structure
- Package router_pkg holds:
  - NUM_PORTS=3
  - ADDR_INVALID=2'b11
  - default TIMEOUT=30
  - the port-index type shared with the FSM and FIFO.
- One sub-module, router_sync_timer: a single-port counter plus sft_rst register, parameterized by TIMEOUT/CNT_W. Instantiated three times.
- Address decode and full mux stay in the top.

## Test plan
1. **Reset:** rstn=0 with empty_*=1.
   - write_enb=000, fifo_full=0, sft_rst_*=0, vld_out_*=0.
   - After release, write_enb_reg=1 alone → write_enb=000.
2. **Steering:** detect_add=1, data_in=01, then write_enb_reg=1 for 22 cycles.
   - write_enb=010 every cycle.
   - full_1=1 → fifo_full=1; full_0=1 alone → fifo_full=0.
   - Header 10 → write_enb=100.
3. **Invalid address and same-cycle update:** header data_in=11 → write_enb=000 and fifo_full=0 with write_enb_reg high.
   - With addr_q=01, detect_add+write_enb_reg together with data_in=10 → write_enb=010 that cycle, 100 the next.
4. **Timeout fires:** empty_2=0, rd_enb_2=0 held.
   - sft_rst_2=1 for exactly one cycle after the 30th stall edge.
   - sft_rst_0/1 stay 0.
   - empty_2=1 next cycle → counter holds 0.
5. **Read restarts timeout:** empty_0=0, rd_enb_0 pulsed during stall cycle 29.
   - No sft_rst_0.
   - A fresh 30-cycle stall is then required to fire.
6. **Reset mid-count:** rstn low during stall cycle 20 of port 1.
   - No sft_rst_1 is ever emitted for that stall.
   - addr_q=11 and write_enb=000 immediately.
   - After release, the count restarts from 0.
